edabk_receiver: RTL and testbench

UART serial receiver, the downstream counterpart of `edabk_transmitter`. It recovers frames from the serial line at 16x oversampling, using the same 3-bit `baudrate` code as `baud_generator`. Each frame is one start bit, DATA_WIDTH data bits sent LSB first, and one stop bit. A good frame produces a one-cycle `valid` pulse with the parallel byte; `valid` is intended to drive the `write` port of an `edabk_io_fifo`.

---
 rtl/edabk_uart_pkg.sv | 26 ++
 rtl/edabk_rx_tick_gen.sv | 37 +++
 rtl/edabk_receiver.sv | 143 ++++++++++++++
 tb/tb_edabk_receiver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/edabk_uart_pkg.sv
// Shared UART constants, receiver state encoding and baud divisor helper.
// Optional build macro used by the receiver: CFG_RX_MAJORITY_EN.
package edabk_uart_pkg;

  localparam int CFG_DATA_WIDTH = 8;
  localparam int RX_OVERSAMPLE  = 16;

  localparam int BAUD_RATES [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_t;

  // Clocks per oversample tick, floored and never below 1.
  function automatic int baud_div(input int clk_freq, input int code);
    int d;
    d = clk_freq / (BAUD_RATES[code[2:0]] * RX_OVERSAMPLE);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/edabk_rx_tick_gen.sv
// Oversample tick generator: one tick every div clocks, tick_cnt counts 0..15 per bit.
// clear restarts the bit timing; load latches a new divisor.
module edabk_rx_tick_gen (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] div_in,
  output logic        tick,
  output logic [3:0]  tick_cnt
);

  logic [15:0] div_q;
  logic [15:0] div_cnt;

  assign tick = (div_cnt == div_q - 16'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q    <= 16'd1;
      div_cnt  <= 16'd0;
      tick_cnt <= 4'd0;
    end else begin
      if (load) div_q <= div_in;
      if (clear) begin
        div_cnt  <= 16'd0;
        tick_cnt <= 4'd0;
      end else if (tick) begin
        div_cnt  <= 16'd0;
        tick_cnt <= tick_cnt + 4'd1;
      end else begin
        div_cnt  <= div_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/edabk_receiver.sv
// UART receiver, 16x oversampling, start + DATA_WIDTH data bits (LSB first) + stop.
// Define CFG_RX_MAJORITY_EN for 2-of-3 voting at ticks 7/8/9 instead of one sample at tick 8.
module edabk_receiver
  import edabk_uart_pkg::*;
#(
  parameter int DATA_WIDTH = CFG_DATA_WIDTH,
  parameter int CLK_FREQ   = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            baudrate,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_out,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy,
  output logic [2:0]            rx_state
);

  localparam logic [2:0] S_WAIT_IDLE = WAIT_IDLE;
  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_START     = START;
  localparam logic [2:0] S_DATA      = DATA;
  localparam logic [2:0] S_STOP      = STOP;

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [15:0] BAUD_DIV [8] = '{
    16'(baud_div(CLK_FREQ, 0)), 16'(baud_div(CLK_FREQ, 1)),
    16'(baud_div(CLK_FREQ, 2)), 16'(baud_div(CLK_FREQ, 3)),
    16'(baud_div(CLK_FREQ, 4)), 16'(baud_div(CLK_FREQ, 5)),
    16'(baud_div(CLK_FREQ, 6)), 16'(baud_div(CLK_FREQ, 7))
  };

`ifdef CFG_RX_MAJORITY_EN
  localparam logic [3:0] DECIDE_CNT = 4'd9;
`else
  localparam logic [3:0] DECIDE_CNT = 4'd8;
`endif

  logic                  rx_meta, rx_s, rx_prev;
  logic [2:0]            state;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  tick;
  logic [3:0]            tick_cnt;
  logic                  start_det, decide, wrap, sample;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_det = (state == S_IDLE) && rx_prev && !rx_s;
  assign decide    = tick && (tick_cnt == DECIDE_CNT);
  assign wrap      = tick && (tick_cnt == 4'd15);
  assign busy      = (state != S_IDLE);
  assign rx_state  = state;

  edabk_rx_tick_gen u_tick_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (start_det),
    .load     (start_det),
    .div_in   (BAUD_DIV[baudrate]),
    .tick     (tick),
    .tick_cnt (tick_cnt)
  );

`ifdef CFG_RX_MAJORITY_EN
  // Samples at ticks 7 and 8; the tick-9 sample is taken live at the decision.
  logic [1:0] early;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      early <= 2'b00;
    end else if (tick && tick_cnt == 4'd7) begin
      early[0] <= rx_s;
    end else if (tick && tick_cnt == 4'd8) begin
      early[1] <= rx_s;
    end
  end

  assign sample = (early[0] & early[1]) | (early[0] & rx_s) | (early[1] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_WAIT_IDLE;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_out    <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_WAIT_IDLE: if (rx_s) state <= S_IDLE;
        S_IDLE:      if (start_det) state <= S_START;
        S_START: begin
          if (decide && sample) begin
            state <= S_IDLE;
          end else if (wrap) begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (decide) shreg <= {sample, shreg[DATA_WIDTH-1:1]};
          if (wrap) begin
            if (bit_idx == IDX_W'(DATA_WIDTH - 1)) state <= S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end
        end
        S_STOP: begin
          // Leave at the decision tick so a following start bit is not missed.
          if (decide) begin
            if (sample) begin
              rx_out <= shreg;
              valid  <= 1'b1;
              state  <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_WAIT_IDLE;
            end
          end
        end
        default: state <= S_WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edabk_receiver.sv
// Self-checking bench for edabk_receiver: serial frames in, scoreboard on valid pulses.
module tb_edabk_receiver;

  localparam int DW       = 8;
  localparam int CLK_FREQ = 614_400;  // div = 4 at code 3, 2 at code 4
  localparam int BIT3     = 64;       // clocks per bit at code 3
  localparam int BIT4     = 32;       // clocks per bit at code 4

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    baudrate = 3'd3;
  logic          rx_in = 1'b1;
  logic [DW-1:0] rx_out;
  logic          valid;
  logic          frame_err;
  logic          busy;
  logic [2:0]    rx_state;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic          valid_d = 1'b0;

  logic [DW-1:0] snap_rx_out;
  logic          snap_valid, snap_ferr, snap_busy;

  // clock/reset
  always #5 clk = ~clk;

  edabk_receiver #(.DATA_WIDTH(DW), .CLK_FREQ(CLK_FREQ)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .baudrate  (baudrate),
    .rx_in     (rx_in),
    .rx_out    (rx_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .rx_state  (rx_state)
  );

  // scoreboard
  always @(negedge clk) begin
    if (valid && frame_err) begin
      checks++; errors++;
      $display("FAIL pulse_overlap valid=%b frame_err=%b required not both high", valid, frame_err);
    end
    if (valid) begin
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid rx_out=%h with no word expected", rx_out);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rx_out !== e) begin
          errors++;
          $display("FAIL rx_word got=%h exp=%h", rx_out, e);
        end
      end
      checks++;
      if (valid_d) begin
        errors++;
        $display("FAIL valid_width valid high for more than one cycle");
      end
    end
    if (frame_err) ferr_cnt++;
    valid_d = valid;
  end

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic stop_bit, input int bit_clks,
                            input int glitch_at, input int rst_at);
    logic [DW+1:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int c = 0; c < (DW + 2) * bit_clks; c++) begin
      @(negedge clk);
      if (c == rst_at + 2) begin
        snap_rx_out = rx_out;
        snap_valid  = valid;
        snap_ferr   = frame_err;
        snap_busy   = busy;
        reset_n     = 1'b1;
      end
      rx_in = frame[c / bit_clks];
      if (glitch_at >= 0 && c >= glitch_at && c < glitch_at + bit_clks / 16) rx_in = ~rx_in;
      if (c == rst_at) reset_n = 1'b0;
    end
  endtask

  // tests
  task automatic test_reset;
    reset_n = 1'b0;
    rx_in   = 1'b1;
    wait_clks(4);
    checks++; if (rx_out !== 8'h00)  begin errors++; $display("FAIL reset_rx_out got=%h exp=00", rx_out); end
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
    reset_n = 1'b1;
    wait_clks(4);
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_to_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, BIT3, -1, -1);
    wait_clks(2 * BIT3);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL basic_valid_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (ferr_cnt - f0 !== 0)  begin errors++; $display("FAIL basic_frame_err got=%0d exp=0", ferr_cnt - f0); end
    checks++; if (rx_out !== 8'hA5)     begin errors++; $display("FAIL basic_hold got=%h exp=a5", rx_out); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_cnt;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b1, BIT3, -1, -1);
    send_frame(8'hC3, 1'b1, BIT3, -1, -1);
    wait_clks(2 * BIT3);
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count got=%0d exp=2", valid_cnt - v0); end
    checks++; if (rx_out !== 8'hC3)     begin errors++; $display("FAIL b2b_hold got=%h exp=c3", rx_out); end
  endtask

  task automatic test_baud4;
    int v0;
    v0 = valid_cnt;
    baudrate = 3'd4;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, BIT4, -1, -1);
    wait_clks(2 * BIT4);
    baudrate = 3'd3;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL baud4_valid_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (rx_out !== 8'h96)     begin errors++; $display("FAIL baud4_hold got=%h exp=96", rx_out); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hFF, 1'b0, BIT3, -1, -1);
    wait_clks(3 * BIT3);
    checks++; if (ferr_cnt - f0 !== 1)  begin errors++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL ferr_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (rx_out !== 8'h96)     begin errors++; $display("FAIL ferr_rx_out got=%h exp=96", rx_out); end
    checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL ferr_busy_low_line got=%b exp=1", busy); end
    rx_in = 1'b1;
    wait_clks(6);
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL ferr_busy_release got=%b exp=0", busy); end
  endtask

  task automatic test_false_start;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    @(negedge clk); rx_in = 1'b0;
    wait_clks(BIT3 / 2);
    rx_in = 1'b1;
    wait_clks(2 * BIT3);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL false_start_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (ferr_cnt - f0 !== 0)  begin errors++; $display("FAIL false_start_ferr got=%0d exp=0", ferr_cnt - f0); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL false_start_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hF8, 1'b1, BIT3, -1, 4 * BIT3 + 20);
    wait_clks(2 * BIT3);
    checks++; if (snap_rx_out !== 8'h00) begin errors++; $display("FAIL rst_mid_rx_out got=%h exp=00", snap_rx_out); end
    checks++; if (snap_valid !== 1'b0)   begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", snap_valid); end
    checks++; if (snap_ferr !== 1'b0)    begin errors++; $display("FAIL rst_mid_ferr got=%b exp=0", snap_ferr); end
    checks++; if (snap_busy !== 1'b1)    begin errors++; $display("FAIL rst_mid_busy got=%b exp=1", snap_busy); end
    checks++; if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin
      errors++; $display("FAIL rst_mid_no_pulse valid=%0d ferr=%0d exp=0/0", valid_cnt - v0, ferr_cnt - f0);
    end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, BIT3, -1, -1);
    wait_clks(2 * BIT3);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL rst_mid_next_frame got=%0d exp=1", valid_cnt - v0); end
    checks++; if (rx_out !== 8'h5A)     begin errors++; $display("FAIL rst_mid_next_word got=%h exp=5a", rx_out); end
  endtask

  task automatic test_glitch;
    logic [DW-1:0] e;
`ifdef CFG_RX_MAJORITY_EN
    e = 8'h00;
`else
    e = 8'h04;
`endif
    exp_q.push_back(e);
    // tick_cnt 8 of data bit 2 samples rx_in 36 clocks into frame bit 3
    send_frame(8'h00, 1'b1, BIT3, 3 * BIT3 + 34, -1);
    wait_clks(2 * BIT3);
    checks++; if (rx_out !== e) begin errors++; $display("FAIL glitch_word got=%h exp=%h", rx_out, e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_baud4();
    test_frame_err();
    test_false_start();
    test_reset_mid();
    test_glitch();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d words left exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
